// File: rtl/bcd_ascii_serializer.sv
// bcd_ascii_serializer: validates a sign+3-digit BCD word and streams it as ASCII with optional leading-zero suppression and CR LF
module bcd_ascii_serializer #(
  parameter bit LZ_SUPPRESS = 1'b1,
  parameter bit TERM_CRLF = 1'b1
) (
  input  logic            iClk,
  input  logic            iReset,
  input  logic [3:0][3:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [7:0]      o_byte,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_err
);
  typedef enum logic [2:0] {IDLE, SIGN, DIG2, DIG1, DIG0, CR, LF} state_t;
  state_t state_q, state_d;
  logic [3:0] h_q, t_q, u_q;
  logic skip2_q, skip1_q, valid_q, err_q;
  logic [7:0] byte_q, byte_d;
  logic capture, word_ok;
  assign o_ready = state_q == IDLE && !iReset;
  assign o_byte = byte_q;
  assign o_valid = valid_q;
  assign o_err = err_q;
  assign capture = i_valid && o_ready;
  assign word_ok = i_data[3][3:1] == 3'b110 && i_data[2] <= 4'd9 && i_data[1] <= 4'd9 && i_data[0] <= 4'd9;
  // next non-skipped state after the current byte transfers, and the byte it presents
  always_comb begin
    state_d = state_q == SIGN ? (skip1_q ? DIG0 : skip2_q ? DIG1 : DIG2) :
              state_q == DIG2 ? DIG1 :
              state_q == DIG1 ? DIG0 :
              state_q == DIG0 ? (TERM_CRLF ? CR : IDLE) :
              state_q == CR   ? LF : IDLE;
    byte_d = state_d == DIG2 ? {4'h3, h_q} :
             state_d == DIG1 ? {4'h3, t_q} :
             state_d == DIG0 ? {4'h3, u_q} :
             state_d == CR   ? 8'h0D :
             state_d == LF   ? 8'h0A : 8'h00;
  end
  // capture/validate in IDLE, otherwise advance one state per accepted byte
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= IDLE;
      byte_q <= 8'h00;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= capture && !word_ok;
      if (capture && word_ok) begin
        state_q <= SIGN;
        h_q <= i_data[2];
        t_q <= i_data[1];
        u_q <= i_data[0];
        skip2_q <= LZ_SUPPRESS && i_data[2] == 4'd0;
        skip1_q <= LZ_SUPPRESS && i_data[2] == 4'd0 && i_data[1] == 4'd0;
        byte_q <= i_data[3][0] ? 8'h2D : 8'h2B;
        valid_q <= 1'b1;
      end else if (valid_q && i_ready) begin
        state_q <= state_d;
        byte_q <= byte_d;
        valid_q <= state_d != IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// tb_bcd_ascii_serializer: directed stimulus against three parameterisations, checked every cycle by a frame-level byte model
module tb_bcd_ascii_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0][3:0] din [3];
  logic vin [3], rin [3], ordy [3], ovld [3], oerr [3];
  logic [7:0] obyte [3];
  bcd_ascii_serializer #(.LZ_SUPPRESS(1'b1), .TERM_CRLF(1'b1)) u0 (
    .iClk(clk), .iReset(rst), .i_data(din[0]), .i_valid(vin[0]), .o_ready(ordy[0]),
    .o_byte(obyte[0]), .o_valid(ovld[0]), .i_ready(rin[0]), .o_err(oerr[0]));
  bcd_ascii_serializer #(.LZ_SUPPRESS(1'b0), .TERM_CRLF(1'b1)) u1 (
    .iClk(clk), .iReset(rst), .i_data(din[1]), .i_valid(vin[1]), .o_ready(ordy[1]),
    .o_byte(obyte[1]), .o_valid(ovld[1]), .i_ready(rin[1]), .o_err(oerr[1]));
  bcd_ascii_serializer #(.LZ_SUPPRESS(1'b1), .TERM_CRLF(1'b0)) u2 (
    .iClk(clk), .iReset(rst), .i_data(din[2]), .i_valid(vin[2]), .o_ready(ordy[2]),
    .o_byte(obyte[2]), .o_valid(ovld[2]), .i_ready(rin[2]), .o_err(oerr[2]));
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_cap = -1;
  bit chk = 1'b0;
  bit b2b = 1'b0;
  logic [7:0] eb [3][6];
  int en [3] = '{0, 0, 0};
  int ep [3] = '{0, 0, 0};
  int sent [3] = '{0, 0, 0};
  bit err_e [3] = '{0, 0, 0};
  task automatic check(input string nm, input int i, input logic [47:0] a, input logic [47:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, a, e);
    end
  endtask
  function automatic int model(input logic [15:0] w, input bit lz, input bit tc, output logic [7:0] b [6]);
    int h, t, u, n;
    h = int'(w[11:8]);
    t = int'(w[7:4]);
    u = int'(w[3:0]);
    n = 0;
    for (int k = 0; k < 6; k++) b[k] = 8'h00;
    if (!(w[15:12] == 4'hC || w[15:12] == 4'hD) || h > 9 || t > 9 || u > 9) return 0;
    b[n] = w[15:12] == 4'hC ? 8'h2B : 8'h2D; n++;
    if (!lz || h != 0) begin b[n] = 8'(48 + h); n++; end
    if (!lz || h != 0 || t != 0) begin b[n] = 8'(48 + t); n++; end
    b[n] = 8'(48 + u); n++;
    if (tc) begin b[n] = 8'h0D; b[n+1] = 8'h0A; n += 2; end
    return n;
  endfunction
  task automatic pin(input logic [15:0] w, input bit lz, input bit tc, input logic [47:0] e, input int en_exp);
    logic [7:0] b [6];
    logic [47:0] v;
    int n;
    n = model(w, lz, tc, b);
    v = '0;
    for (int k = 0; k < n; k++) v = {v[39:0], b[k]};
    check("pin_len", 0, 48'(n), 48'(en_exp));
    check("pin_bytes", 0, v, e);
  endtask
  always @(negedge clk) begin
    logic [7:0] b [6];
    int n;
    bit busy;
    if (chk) begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
        busy = ep[i] < en[i];
        check("o_valid", i, 48'(ovld[i]), 48'(busy));
        check("o_byte", i, 48'(obyte[i]), 48'(busy ? eb[i][ep[i] % 6] : 8'h00));
        check("o_ready", i, 48'(ordy[i]), 48'(!busy && !rst));
        check("o_err", i, 48'(oerr[i]), 48'(err_e[i]));
        err_e[i] = 1'b0;
        if (rst) begin
          ep[i] = 0;
          en[i] = 0;
        end else if (busy && rin[i]) begin
          ep[i]++;
          sent[i]++;
        end else if (!busy && vin[i]) begin
          n = model(din[i], i != 1, i != 2, b);
          if (n == 0) err_e[i] = 1'b1;
          else begin
            eb[i] = b;
            en[i] = n;
            ep[i] = 0;
          end
          if (i == 2 && b2b && n != 0) begin
            if (last_cap >= 0) check("b2b_gap", 2, 48'(cyc - last_cap), 48'd5);
            last_cap = cyc;
          end
        end
      end
    end
  end
  task automatic wait_ready(input int i);
    int k = 0;
    while (!ordy[i] && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ordy[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout inst%0d: o_ready still %b, required 1", i, ordy[i]);
    end
  endtask
  task automatic send(input int i, input logic [15:0] w);
    wait_ready(i);
    din[i] = w;
    vin[i] = 1'b1;
    @(posedge clk); #1;
    vin[i] = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      vin[i] = 1'b0;
      rin[i] = 1'b1;
    end
    pin(16'hC123, 1, 1, 48'h2B3132330D0A, 6);
    pin(16'hD007, 1, 1, 48'h2D370D0A, 4);
    pin(16'hC000, 1, 1, 48'h2B300D0A, 4);
    pin(16'hC050, 1, 1, 48'h2B35300D0A, 5);
    pin(16'hC007, 0, 1, 48'h2B3030370D0A, 6);
    pin(16'hD100, 1, 0, 48'h2D313030, 4);
    pin(16'hD000, 1, 1, 48'h2D300D0A, 4);
    pin(16'hC1A3, 1, 1, 48'h0, 0);
    pin(16'hE123, 1, 1, 48'h0, 0);
    @(posedge clk); #1;
    chk = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 16'hC123);
    send(0, 16'hD007);
    send(0, 16'hC000);
    send(0, 16'hC050);
    send(1, 16'hC007);
    send(0, 16'hD255);
    for (int k = 0; k < 200 && !ordy[0]; k++) begin
      rin[0] = 1'($urandom_range(1));
      vin[0] = 1'($urandom_range(1));
      din[0] = 16'hC777;
      @(posedge clk); #1;
    end
    vin[0] = 1'b0;
    rin[0] = 1'b1;
    send(0, 16'hC1A3);
    send(0, 16'hE123);
    send(0, 16'hC001);
    send(0, 16'hC123);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 16'hC009);
    wait_ready(2);
    b2b = 1'b1;
    din[2] = 16'hD100;
    vin[2] = 1'b1;
    repeat (21) begin @(posedge clk); #1; end
    vin[2] = 1'b0;
    wait_ready(2);
    wait_ready(0);
    b2b = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("bytes_sent", 0, 48'(sent[0]), 48'd35);
    check("bytes_sent", 1, 48'(sent[1]), 48'd6);
    check("b2b_last", 2, 48'(last_cap > 15), 48'd1);
    for (int i = 0; i < 3; i++) check("frame_drained", i, 48'(en[i] - ep[i]), 48'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
